// File: rtl/tone_i2s_out.sv
// Tone generator and I2S serializer for a stereo DAC.
// Two square-wave tone channels swing between volume_min and volume_max.
// Once per 512-clk frame the pair {L,R} is latched, then shifted out MSB
// first with the I2S one-bit delay.
// Clocks: mclk = clk/4, sck = clk/16, lrck = clk/512 (0 = left).
module tone_i2s_out #(
  parameter int CLK_DIV_W = 9,
  parameter int DIV_W     = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      volume_max,
  input  logic [15:0]      volume_min,
  input  logic [DIV_W-1:0] note_div_l,
  input  logic [DIV_W-1:0] note_div_r,
  input  logic             mute,
  output logic             audio_mclk,
  output logic             audio_lrck,
  output logic             audio_sck,
  output logic             audio_sdin,
  output logic             frame_tick
);

  // Frame counter; every audio clock is a plain bit of it.
  logic [CLK_DIV_W-1:0] fcnt;

  // Tone channel state. div_q_* holds last cycle's divider so that a
  // note change can be detected and the phase restarted.
  logic [DIV_W-1:0] tcnt_l, tcnt_r;
  logic [DIV_W-1:0] div_q_l, div_q_r;
  logic             sq_l, sq_r;

  // Serializer state.
  logic [31:0] word;
  logic [15:0] sample_l, sample_r;
  logic [31:0] word_next;
  logic [4:0]  slot_next;
  logic [4:0]  bit_idx;
  logic        latch_edge;
  logic        slot_edge;

  assign audio_mclk = fcnt[1];
  assign audio_sck  = fcnt[3];
  assign audio_lrck = fcnt[CLK_DIV_W-1];

  // Free-running frame counter, wraps at the end of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt <= '0;
    else     fcnt <= fcnt + CLK_DIV_W'(1);
  end

  // Left tone: restart on silence or note change, otherwise count out
  // the half-period and flip the square bit. A note change beats the
  // terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_l  <= '0;
      sq_l    <= 1'b0;
      div_q_l <= '0;
    end else begin
      div_q_l <= note_div_l;
      if (note_div_l == '0 || note_div_l != div_q_l) begin
        tcnt_l <= '0;
        sq_l   <= 1'b0;
      end else if (tcnt_l >= note_div_l - DIV_W'(1)) begin
        tcnt_l <= '0;
        sq_l   <= ~sq_l;
      end else begin
        tcnt_l <= tcnt_l + DIV_W'(1);
      end
    end
  end

  // Right tone: same behaviour as the left channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_r  <= '0;
      sq_r    <= 1'b0;
      div_q_r <= '0;
    end else begin
      div_q_r <= note_div_r;
      if (note_div_r == '0 || note_div_r != div_q_r) begin
        tcnt_r <= '0;
        sq_r   <= 1'b0;
      end else if (tcnt_r >= note_div_r - DIV_W'(1)) begin
        tcnt_r <= '0;
        sq_r   <= ~sq_r;
      end else begin
        tcnt_r <= tcnt_r + DIV_W'(1);
      end
    end
  end

  // Sample selection and serializer slot decode.
  always_comb begin
    sample_l   = (mute || note_div_l == '0) ? 16'h0000 : (sq_l ? volume_max : volume_min);
    sample_r   = (mute || note_div_r == '0) ? 16'h0000 : (sq_r ? volume_max : volume_min);
    word_next  = {sample_l, sample_r};
    latch_edge = (fcnt == CLK_DIV_W'(15));
    slot_edge  = (fcnt[3:0] == 4'hF);
    slot_next  = fcnt[CLK_DIV_W-1 -: 5] + 5'd1;
    // (32 - s') mod 32: slot 1 -> bit 31, slot 0 -> bit 0.
    bit_idx    = 5'd0 - slot_next;
  end

  // Word latch at the start of slot 1, and bit output on every falling
  // sck edge. Slot 1 takes its bit straight from the word being latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      audio_sdin <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= latch_edge;
      if (latch_edge) word <= word_next;
      if (slot_edge) begin
        if (latch_edge) audio_sdin <= word_next[31];
        else            audio_sdin <= word[bit_idx];
      end
    end
  end

endmodule

// File: tb/tb_tone_i2s_out.sv
// Bench for tone_i2s_out: reference model of the tone channels and frame
// timing, an I2S decoder on the serial pins, and an expected-word queue.
module tb_tone_i2s_out;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] volume_max, volume_min;
  logic [21:0] note_div_l, note_div_r;
  logic        mute;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick;

  always #5 clk = ~clk;

  tone_i2s_out #(.CLK_DIV_W(9), .DIV_W(22)) dut (
    .clk        (clk),
    .rst        (rst),
    .volume_max (volume_max),
    .volume_min (volume_min),
    .note_div_l (note_div_l),
    .note_div_r (note_div_r),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .frame_tick (frame_tick)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // cyc counts clk edges since reset release. A tone channel running at a
  // steady divider d for p edges since its restart is high when
  // (p / d) is odd.
  int unsigned cyc     = 0;
  int unsigned phase_l = 0, phase_r = 0;
  int unsigned last_l  = 0, last_r  = 0;

  function automatic logic [15:0] model_sample(input int unsigned div, input int unsigned last,
                                               input int unsigned phase, input logic m,
                                               input logic [15:0] vmax, input logic [15:0] vmin);
    logic sq;
    if (m || div == 0) return 16'h0000;
    sq = (last == 0) ? 1'b0 : (((phase / last) % 2) == 1);
    return sq ? vmax : vmin;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc     <= 0;
      phase_l <= 0;
      phase_r <= 0;
      last_l  <= 0;
      last_r  <= 0;
      exp_q.delete();
    end else begin
      if (cyc % 512 == 15)
        exp_q.push_back({model_sample(note_div_l, last_l, phase_l, mute, volume_max, volume_min),
                         model_sample(note_div_r, last_r, phase_r, mute, volume_max, volume_min)});
      phase_l <= (note_div_l == 0 || note_div_l != last_l) ? 0 : phase_l + 1;
      phase_r <= (note_div_r == 0 || note_div_r != last_r) ? 0 : phase_r + 1;
      last_l  <= note_div_l;
      last_r  <= note_div_r;
      cyc     <= cyc + 1;
    end
  end

  // ---------------- monitor / I2S decoder ----------------
  logic        prev_sck = 1'b0, prev_lrck = 1'b0, left_valid = 1'b0;
  logic [31:0] sr = '0;
  logic [15:0] left_word = '0, last_left = '0, last_right = '0;
  int          sdin_ones = 0;
  int          pairs = 0;

  // Checks the clock pins against the cycle count and decodes the stream
  // on each rising sck: a rising lrck closes the left word, a falling one
  // closes the right word.
  always @(negedge clk) begin
    logic [31:0] nsr;
    logic [31:0] exp_w;
    if (rst) begin
      prev_sck   <= 1'b0;
      prev_lrck  <= 1'b0;
      sr         <= '0;
      left_valid <= 1'b0;
    end else begin
      check_val("mclk", 32'(audio_mclk), 32'((cyc % 4) >= 2));
      check_val("sck", 32'(audio_sck), 32'((cyc % 16) >= 8));
      check_val("lrck", 32'(audio_lrck), 32'((cyc % 512) >= 256));
      check_val("frame_tick", 32'(frame_tick), 32'((cyc % 512) == 16));
      if (audio_sdin) sdin_ones <= sdin_ones + 1;
      prev_sck <= audio_sck;
      if (audio_sck && !prev_sck) begin
        nsr = {sr[30:0], audio_sdin};
        sr <= nsr;
        if (audio_lrck && !prev_lrck) begin
          left_word  <= nsr[15:0];
          last_left  <= nsr[15:0];
          left_valid <= 1'b1;
        end else if (!audio_lrck && prev_lrck && left_valid) begin
          last_right <= nsr[15:0];
          pairs      <= pairs + 1;
          check_val("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check_val("left_word", 32'(left_word), 32'(exp_w[31:16]));
            check_val("right_word", 32'(nsr[15:0]), 32'(exp_w[15:0]));
          end
        end
        prev_lrck <= audio_lrck;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_pos(input int pos);
    for (int i = 0; i < 600 && (cyc % 512) != pos; i++) @(negedge clk);
    check_val("reach_frame_pos", cyc % 512, pos);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_mclk"}, 32'(audio_mclk), 32'd0);
    check_val({tag, "_lrck"}, 32'(audio_lrck), 32'd0);
    check_val({tag, "_sck"}, 32'(audio_sck), 32'd0);
    check_val({tag, "_sdin"}, 32'(audio_sdin), 32'd0);
    check_val({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
  endtask

  function automatic logic [21:0] rand_div();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 6) return 22'(sel);
    return 22'($urandom_range(7, 600));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int snap;
    rst = 1'b0;
    volume_max = 16'h0000;
    volume_min = 16'h0000;
    note_div_l = '0;
    note_div_r = '0;
    mute = 1'b0;
    #1 rst = 1'b1;
    wait_cycles(3);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Silence: no divider, the data pin stays low for three frames.
    snap = sdin_ones;
    wait_cycles(1536);
    check_val("silent_sdin_ones", sdin_ones - snap, 0);

    // Slow tone: low half first, high half after the half-period.
    volume_max = 16'h0600;
    volume_min = 16'hFA00;
    note_div_l = 22'd20000;
    wait_cycles(1536);
    check_val("slow_tone_low", 32'(last_left), 32'h0000FA00);
    check_val("slow_tone_right", 32'(last_right), 32'h00000000);
    wait_cycles(21000);
    check_val("slow_tone_high", 32'(last_left), 32'h00000600);

    // Fast tone and note changes shortly before the latch edge.
    volume_max = 16'h1234;
    volume_min = 16'hEDCB;
    note_div_l = 22'd4;
    wait_cycles(1024);
    wait_frame_pos(10);
    note_div_l = 22'd6;
    wait_cycles(600);
    wait_frame_pos(8);
    note_div_l = 22'd4;
    note_div_r = 22'd3;
    wait_cycles(1100);

    // Mute for two frames, then release.
    mute = 1'b1;
    wait_cycles(1100);
    mute = 1'b0;
    wait_cycles(600);

    // Random volumes, dividers, mute and change timing.
    for (int it = 0; it < 25; it++) begin
      volume_max = 16'($urandom);
      volume_min = 16'($urandom);
      note_div_l = rand_div();
      note_div_r = rand_div();
      mute = ($urandom_range(0, 7) == 0);
      wait_cycles($urandom_range(300, 1300));
    end

    // Reset in the middle of a frame.
    wait_frame_pos(300);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midframe_reset");
    volume_max = 16'h7FFF;
    volume_min = 16'h8001;
    note_div_l = 22'd5;
    note_div_r = 22'd0;
    mute = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1600);

    check_val("pairs_decoded_min", 32'(pairs >= 50), 32'd1);
    check_val("exp_q_drained", 32'(exp_q.size() <= 1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_i2s_out.md
# tone_i2s_out

Tone generator and I2S serializer for the on-board stereo DAC (Pmod I2S class, 100 MHz system clock). It consumes the signed 16-bit amplitude limits `volume_max` and `volume_min` produced by the volume-control stage. It builds a square wave per channel at a programmable half-period, swinging between those limits. It streams the left/right samples to the DAC as 16-bit I2S frames.

## Interface
Parameters:
- `CLK_DIV_W`, 9: frame counter width; the frame is 2^9 = 512 clk long.
- `DIV_W`, 22: width of the note half-period inputs.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `volume_max`  in  16  signed sample used for the high half of the square wave.
- `volume_min`  in  16  signed sample used for the low half of the square wave.
- `note_div_l`  in  DIV_W  left tone half-period in clk cycles; 0 = silent.
- `note_div_r`  in  DIV_W  right tone half-period in clk cycles; 0 = silent.
- `mute`  in  1  forces both samples to 0.
- `audio_mclk`  out  1  master clock, clk/4.
- `audio_lrck`  out  1  word select, clk/512; 0 = left, 1 = right.
- `audio_sck`  out  1  serial bit clock, clk/16.
- `audio_sdin`  out  1  serial data, MSB first, I2S one-bit delay.
- `frame_tick`  out  1  one-cycle pulse when a new {L,R} word is latched.

## Operation
- Frame counter `fcnt[8:0]` free-runs and wraps 511→0.
  - `audio_mclk = fcnt[1]`, `audio_sck = fcnt[3]`, `audio_lrck = fcnt[8]`.
  - Slot index is `s = fcnt[8:4]`, giving 32 slots per frame.
- Tone channel, per side, with counter `tcnt[DIV_W-1:0]` and square bit `sq`:
  - If div == 0: tcnt ← 0, sq ← 0.
  - Else if div differs from the value registered last cycle: tcnt ← 0, sq ← 0. This restarts the phase on a note change.
  - Else if tcnt ≥ div−1: tcnt ← 0, sq ← ~sq.
  - Else: tcnt ← tcnt+1.
  - Output frequency = 100 MHz / (2·div).
- Sample per side = 0 if `mute` or div == 0; otherwise `volume_max` when sq = 1, `volume_min` when sq = 0.
- Word latch:
  - Happens on the edge where fcnt goes 15→16 (start of slot 1).
  - word[31:0] ← {sample_l, sample_r}, and `frame_tick` = 1 for that cycle.
  - Volume and sample values are therefore sampled once per frame. Mid-frame input changes never corrupt a frame.
- Serializer (`audio_sdin` is registered):
  - On every edge where fcnt[3:0] goes 15→0, or 15→16 for slot 1, `audio_sdin` ← word[(32−s′) mod 32], where s′ is the new slot.
  - Slot 1 uses the freshly latched word, so it carries the L MSB.
  - Slots 1..16 carry L[15:0], MSB first.
  - Slots 17..31 carry R[15:1], then slot 0 of the next frame carries R[0] of the previous word.
  - Data therefore changes only while `audio_sck` is low (on its falling edge) and is stable on the sck rising edge.

## Timing
- Reset values: fcnt = 0, tcnt = 0, sq = 0, word = 0, `audio_sdin` = 0, `frame_tick` = 0. All clock outputs are 0 during and directly after reset.
- First `frame_tick` occurs 16 clk after reset release.
- Latency from an input change to the DAC pin:
  - The value is captured at the next word latch, up to 512 clk later.
  - L MSB appears on `audio_sdin` in the same cycle as the latch.
- `mute` and div changes take effect at the next word latch. No partial frames are produced.
- Reset mid-frame aborts the frame immediately; `audio_sdin` = 0 and `audio_lrck` = 0 until restart.
- Simultaneous div change and terminal count: the div change wins (tcnt ← 0, sq ← 0).
- div = 1: sq toggles every clk. This is legal; the sample value is whatever sq holds at the latch edge.

## Test plan
- Reset, then release: `audio_mclk` period 4 clk, `audio_sck` period 16, `audio_lrck` period 512 with low first. `frame_tick` first high at cycle 16 after release, then every 512.
- mute = 0, note_div_l = note_div_r = 0: `audio_sdin` stays 0 for 3 full frames.
- volume_max = 16'h0600, volume_min = 16'hFA00, div_l = 0, div_r = 0, then force sq via div = 1_000_000 (sq = 0 for first frames): the decoded left word = 16'hFA00. After 1_000_000 clk the decoded word = 16'h0600.
- div_l = 4: the left square toggles every 4 clk; sq flips with period 8 clk. Decoded left samples alternate between max and min according to sq at each latch edge; right stays 0.
- Change div_l from 4 to 6 mid-count: tcnt and sq reset on the next clk, and the next toggle occurs 6 clk later.
- Assert `rst` at fcnt = 300: all outputs go to 0 asynchronously. After release, the frame restarts from fcnt = 0 and the first latched word matches the current inputs.
